fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequential instruction-fetch controller for the RISC-V core. It owns the architectural PC register and sequences instruction-memory requests over a request/grant/response handshake. It presents fetched instructions to decode with a valid/stall handshake and applies redirects computed by the branch-target adder. It sits between the imem port and the decode stage, replacing the free-running PC register plus next-PC mux.

## Interface
- RESET_VECTOR, 32'h0000_0000: first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100: fetch address substituted for a misaligned redirect target.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- Stall  in  1  decode cannot accept the presented instruction this cycle.
- PCSrc  in  1  redirect request; single-cycle qualifier for PCTarget.
- PCTarget  in  32  redirect address from the branch-target adder.
- ImemReq  out  1  fetch request to instruction memory.
- ImemAddr  out  32  fetch address; word aligned.
- ImemGnt  in  1  memory accepted the request this cycle.
- ImemRValid  in  1  read data valid.
- ImemRData  in  32  read data.
- Instr  out  32  instruction presented to decode.
- InstrValid  out  1  Instr/PC valid.
- PC  out  32  address of Instr.
- PCPlus4  out  32  PC + 4, combinational, modulo 2^32.
- MisalignTrap  out  1  one-cycle pulse on a misaligned redirect.

## Operation
- States: BOOT, REQ, WAIT, HOLD.
- Registers: FetchPC (next address), PC, Instr, Kill flag, state.
- BOOT: entered on reset; goes to REQ on the next edge with FetchPC = RESET_VECTOR.
- REQ: ImemReq = 1, ImemAddr = FetchPC. ImemAddr must stay stable until ImemGnt. On ImemGnt, go to WAIT.
- WAIT: ImemReq = 0. On ImemRValid with Kill = 0: Instr <= ImemRData, PC <= FetchPC, go to HOLD. With Kill = 1: discard data, clear Kill, go to REQ.
- HOLD: InstrValid = 1.
  - Stall = 1: hold Instr and PC unchanged.
  - Stall = 0: the instruction is consumed this cycle; FetchPC <= PC + 4; go to REQ.
- Only one outstanding request at any time.
- Redirect (PCSrc = 1): the new FetchPC is PCTarget, or TRAP_VECTOR when PCTarget[1:0] != 0.
  - In REQ: FetchPC update is deferred until after the grant so ImemAddr stays stable. Set Kill and latch the target in a pending register. The pending target becomes FetchPC when WAIT discards the response.
  - In WAIT: set Kill; the in-flight response is discarded, including when ImemRValid arrives in the same cycle as PCSrc.
  - In HOLD: InstrValid drops next cycle and the instruction is dropped whether or not Stall is set; redirect wins over Stall. Go to REQ with the new FetchPC.
  - In BOOT: the redirect is ignored.
- A second redirect before the first is applied overwrites the pending target; the last one wins.
- A misaligned target raises MisalignTrap for exactly the cycle after PCSrc.
- Arithmetic: all address sums are 32-bit and wrap; 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values (asynchronous): state BOOT, FetchPC = PC = ImemAddr = RESET_VECTOR, ImemReq 0, Instr 32'h0000_0013 (NOP), InstrValid 0, MisalignTrap 0, Kill 0.
- Reset asserted mid-transaction aborts immediately. Responses arriving during reset or BOOT are ignored.
- Zero-wait memory (ImemGnt in the ImemReq cycle, ImemRValid one cycle later):
  - reset release -> ImemReq at cycle 1.
  - InstrValid at cycle 3.
  - steady state: one instruction per 3 cycles with Stall = 0.
- Each ImemGnt wait cycle and each ImemRValid wait cycle adds one cycle. There is no timeout.
- Redirect in HOLD: ImemReq with the target on the next cycle. Redirect in WAIT: ImemReq with the target the cycle after the discarded response.

## Test plan
- Reset release, zero-wait memory returning 32'h0050_0093 at 0x0: ImemReq cycle 1 with ImemAddr = 0x0; InstrValid cycle 3 with Instr = 32'h0050_0093, PC = 0x0, PCPlus4 = 0x4; next request to 0x4.
- Stall held 4 cycles in HOLD: Instr and PC stable and no ImemReq; release gives a request to PC + 4 the cycle after Stall falls.
- ImemGnt withheld 3 cycles with PCSrc = 1, PCTarget = 0x40 in the first of them: ImemAddr stays at the old address until grant; the response is discarded; the next request is to 0x40 and InstrValid shows PC = 0x40.
- PCSrc = 1 with PCTarget = 0x22 in HOLD while Stall = 1: MisalignTrap pulses once, InstrValid drops, the next request is to TRAP_VECTOR 0x100.
- PCSrc coincident with ImemRValid in WAIT: data not presented (InstrValid stays 0) and the target is fetched next.
- rst pulsed low during WAIT: outputs return to reset values immediately; the late ImemRValid is ignored; fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_controller.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fetch_controller
//
// Sequential instruction-fetch controller. Owns the architectural PC and runs
// one instruction-memory transaction at a time over a request/grant/response
// handshake. The fetched word is presented to decode with a valid/stall
// handshake. Redirects from the branch-target adder are applied as soon as the
// memory handshake allows it.
//
// Parameters
//   RESET_VECTOR  first fetch address after reset
//   TRAP_VECTOR   fetch address substituted for a misaligned redirect target
//
// Ports
//   clk           single clock, rising-edge
//   rst           asynchronous reset, active low
//   Stall         decode cannot accept the presented instruction this cycle
//   PCSrc         redirect request, single-cycle qualifier for PCTarget
//   PCTarget      redirect address
//   ImemReq       fetch request to instruction memory
//   ImemAddr      fetch address (word aligned)
//   ImemGnt       memory accepted the request this cycle
//   ImemRValid    read data valid
//   ImemRData     read data
//   Instr         instruction presented to decode
//   InstrValid    Instr/PC valid
//   PC            address of Instr
//   PCPlus4       PC + 4 (combinational, wraps at 2^32)
//   MisalignTrap  one-cycle pulse the cycle after a misaligned redirect
// ----------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        MisalignTrap
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;    // address of the next (or current) request
    logic [31:0] pending_pc;  // redirect target waiting for the killed response
    logic        kill;        // the in-flight response must be discarded

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    // A misaligned redirect is replaced by the trap vector so that every
    // fetch address stays word aligned.
    function automatic logic [31:0] redirect_target(input logic [31:0] addr);
        return is_misaligned(addr) ? TRAP_VECTOR : addr;
    endfunction

    // The request address is held in fetch_pc, which never changes while a
    // request is waiting for its grant.
    assign ImemAddr = fetch_pc;
    assign PCPlus4  = PC + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_BOOT;
            fetch_pc     <= RESET_VECTOR;
            pending_pc   <= RESET_VECTOR;
            kill         <= 1'b0;
            PC           <= RESET_VECTOR;
            Instr        <= NOP;
            ImemReq      <= 1'b0;
            InstrValid   <= 1'b0;
            MisalignTrap <= 1'b0;
        end else begin
            // Redirects are ignored in BOOT, so they cannot trap there either.
            MisalignTrap <= (state != ST_BOOT) && PCSrc && is_misaligned(PCTarget);

            case (state)
                ST_BOOT: begin
                    fetch_pc <= RESET_VECTOR;
                    ImemReq  <= 1'b1;
                    state    <= ST_REQ;
                end

                ST_REQ: begin
                    // The address must not move before the grant, so the
                    // redirect is parked and the coming response is killed.
                    if (PCSrc) begin
                        kill       <= 1'b1;
                        pending_pc <= redirect_target(PCTarget);
                    end
                    if (ImemGnt) begin
                        ImemReq <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (ImemRValid) begin
                        if (kill || PCSrc) begin
                            // Discard the response. A redirect arriving in the
                            // same cycle is newer than any parked target.
                            kill     <= 1'b0;
                            fetch_pc <= PCSrc ? redirect_target(PCTarget) : pending_pc;
                            ImemReq  <= 1'b1;
                            state    <= ST_REQ;
                        end else begin
                            Instr      <= ImemRData;
                            PC         <= fetch_pc;
                            InstrValid <= 1'b1;
                            state      <= ST_HOLD;
                        end
                    end else if (PCSrc) begin
                        kill       <= 1'b1;
                        pending_pc <= redirect_target(PCTarget);
                    end
                end

                ST_HOLD: begin
                    // Redirect wins over Stall: the presented instruction is
                    // dropped either way.
                    if (PCSrc) begin
                        fetch_pc   <= redirect_target(PCTarget);
                        InstrValid <= 1'b0;
                        ImemReq    <= 1'b1;
                        state      <= ST_REQ;
                    end else if (!Stall) begin
                        fetch_pc   <= PC + 32'd4;
                        InstrValid <= 1'b0;
                        ImemReq    <= 1'b1;
                        state      <= ST_REQ;
                    end
                end

                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // An ungranted request keeps its address.
    a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        (ImemReq && !ImemGnt) |=> (ImemReq && $stable(ImemAddr)));

    // A new request is never issued while an instruction is presented.
    a_req_valid_excl: assert property (@(posedge clk) disable iff (!rst)
        !(ImemReq && InstrValid));
`endif

endmodule

// File: tb/tb_fetch_controller.sv
`timescale 1ns/1ps
module tb_fetch_controller;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] TV  = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = '0;
    logic        ImemGnt = 1'b0;
    logic        ImemRValid = 1'b0;
    logic [31:0] ImemRData = '0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        MisalignTrap;

    int checks = 0;
    int errors = 0;
    int presented = 0;

    fetch_controller #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRValid(ImemRValid), .ImemRData(ImemRData), .Instr(Instr),
        .InstrValid(InstrValid), .PC(PC), .PCPlus4(PCPlus4), .MisalignTrap(MisalignTrap)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] map_target(input logic [31:0] t);
        return (t[1:0] != 2'b00) ? TV : t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: works on transactions. Expected request addresses and
    // expected presented instructions are pushed when the stimulus that
    // determines them is applied.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } item_t;

    logic [31:0] exp_addr_q[$];
    item_t       exp_instr_q[$];
    logic        exp_trap = 1'b0;

    initial begin : predictor
        bit          boot = 1'b1;
        bit          req_open = 1'b0;
        bit          inflight = 1'b0;
        bit          txn_open = 1'b0;
        bit          killed = 1'b0;
        bit          showing = 1'b0;
        logic [31:0] next_addr = RV;
        logic [31:0] cur_addr = RV;
        logic [31:0] shown_pc = RV;
        item_t       it;
        forever begin
            @(posedge clk);
            if (!rst) begin
                exp_addr_q.delete();
                exp_instr_q.delete();
                exp_addr_q.push_back(RV);
                next_addr = RV;
                boot = 1'b1; req_open = 1'b0; inflight = 1'b0;
                txn_open = 1'b0; killed = 1'b0; showing = 1'b0;
                exp_trap = 1'b0;
            end else if (boot) begin
                boot = 1'b0;
                exp_trap = 1'b0;
            end else begin
                exp_trap = 1'b0;
                if (ImemReq && !req_open) begin
                    req_open = 1'b1;
                    txn_open = 1'b1;
                    killed   = 1'b0;
                    cur_addr = next_addr;
                end
                if (req_open && ImemGnt) begin
                    req_open = 1'b0;
                    inflight = 1'b1;
                end
                if (PCSrc) begin
                    exp_trap  = (PCTarget[1:0] != 2'b00);
                    next_addr = map_target(PCTarget);
                    if (txn_open) killed = 1'b1;
                    if (exp_addr_q.size() > 0) exp_addr_q[exp_addr_q.size() - 1] = next_addr;
                    else exp_addr_q.push_back(next_addr);
                    showing = 1'b0;
                end else if (showing && !Stall) begin
                    showing   = 1'b0;
                    next_addr = shown_pc + 32'd4;
                    exp_addr_q.push_back(next_addr);
                end
                if (inflight && ImemRValid) begin
                    inflight = 1'b0;
                    txn_open = 1'b0;
                    if (!killed) begin
                        it.pc  = cur_addr;
                        it.ins = mem_word(cur_addr);
                        exp_instr_q.push_back(it);
                        showing  = 1'b1;
                        shown_pc = cur_addr;
                    end
                    killed = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares DUT outputs against the expected queues.
    // ------------------------------------------------------------------
    initial begin : monitor
        logic        p_req = 1'b0, p_gnt = 1'b0, p_valid = 1'b0;
        logic        p_stall = 1'b0, p_pcsrc = 1'b0;
        logic [31:0] p_addr = '0, p_pc = '0, p_instr = '0;
        item_t       it;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk_bit("rst_imemreq", ImemReq, 1'b0);
                chk_bit("rst_instrvalid", InstrValid, 1'b0);
                chk_bit("rst_trap", MisalignTrap, 1'b0);
                chk("rst_imemaddr", ImemAddr, RV);
                chk("rst_pc", PC, RV);
                chk("rst_instr", Instr, NOP);
                p_req = 1'b0; p_gnt = 1'b0; p_valid = 1'b0;
                p_stall = 1'b0; p_pcsrc = 1'b0;
            end else begin
                chk_bit("trap", MisalignTrap, exp_trap);
                if (p_req && !p_gnt) begin
                    chk_bit("req_held", ImemReq, 1'b1);
                    chk("addr_stable", ImemAddr, p_addr);
                end else if (ImemReq) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL req_unexpected: got request to %h expected no request", ImemAddr);
                    end else begin
                        chk("req_addr", ImemAddr, exp_addr_q.pop_front());
                    end
                end
                if (p_valid && (!p_stall || p_pcsrc)) begin
                    chk_bit("valid_drop", InstrValid, 1'b0);
                end else if (InstrValid && p_valid) begin
                    chk("hold_pc", PC, p_pc);
                    chk("hold_instr", Instr, p_instr);
                end else if (InstrValid) begin
                    if (exp_instr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL instr_unexpected: got PC %h expected no instruction", PC);
                    end else begin
                        it = exp_instr_q.pop_front();
                        chk("instr_pc", PC, it.pc);
                        chk("instr_word", Instr, it.ins);
                        chk("instr_pcplus4", PCPlus4, it.pc + 32'd4);
                        presented++;
                    end
                end
                p_req = ImemReq; p_gnt = ImemGnt; p_valid = InstrValid;
                p_stall = Stall; p_pcsrc = PCSrc;
                p_addr = ImemAddr; p_pc = PC; p_instr = Instr;
            end
        end
    end

    // Zero-wait transaction from a REQ cycle; returns in the HOLD cycle.
    task automatic serve(input logic [31:0] a);
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0;
        ImemRValid = 1'b1;
        ImemRData = mem_word(a);
        tick();
        ImemRValid = 1'b0;
        ImemRData = '0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus: directed scenarios, then randomized traffic.
    // ------------------------------------------------------------------
    initial begin : stimulus
        bit          outst, prev_gnt, prev_rv;
        logic [31:0] raddr;
        int unsigned r;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) tick();
        chk("reset_instr", Instr, NOP);
        rst = 1'b1;                          // cycle 0 (BOOT)
        tick();                              // cycle 1
        chk_bit("c1_req", ImemReq, 1'b1);
        chk("c1_addr", ImemAddr, 32'h0);
        ImemGnt = 1'b1;
        tick();                              // cycle 2
        ImemGnt = 1'b0;
        chk_bit("c2_noreq", ImemReq, 1'b0);
        chk_bit("c2_novalid", InstrValid, 1'b0);
        ImemRValid = 1'b1;
        ImemRData = 32'h0050_0093;
        tick();                              // cycle 3
        ImemRValid = 1'b0;
        chk_bit("c3_valid", InstrValid, 1'b1);
        chk("c3_instr", Instr, 32'h0050_0093);
        chk("c3_pc", PC, 32'h0);
        chk("c3_pcplus4", PCPlus4, 32'h4);
        tick();                              // cycle 4
        chk_bit("c4_req", ImemReq, 1'b1);
        chk("c4_addr", ImemAddr, 32'h4);

        // Stall held four cycles in HOLD.
        serve(32'h4);
        chk("stall_pc0", PC, 32'h4);
        Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_bit("stall_valid", InstrValid, 1'b1);
            chk("stall_pc", PC, 32'h4);
            chk("stall_instr", Instr, mem_word(32'h4));
            chk_bit("stall_noreq", ImemReq, 1'b0);
        end
        Stall = 1'b0;
        tick();
        chk_bit("release_req", ImemReq, 1'b1);
        chk("release_addr", ImemAddr, 32'h8);

        // Grant withheld three cycles, redirect in the first of them.
        PCSrc = 1'b1;
        PCTarget = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            PCSrc = 1'b0;
            chk_bit("gnt_wait_req", ImemReq, 1'b1);
            chk("gnt_wait_addr", ImemAddr, 32'h8);
        end
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0;
        ImemRValid = 1'b1;
        ImemRData = mem_word(32'h8);
        tick();
        ImemRValid = 1'b0;
        chk_bit("kill_novalid", InstrValid, 1'b0);
        chk_bit("kill_req", ImemReq, 1'b1);
        chk("kill_addr", ImemAddr, 32'h40);
        serve(32'h40);
        chk_bit("redir_valid", InstrValid, 1'b1);
        chk("redir_pc", PC, 32'h40);

        // Misaligned redirect in HOLD while stalled.
        Stall = 1'b1;
        PCSrc = 1'b1;
        PCTarget = 32'h22;
        tick();
        PCSrc = 1'b0;
        Stall = 1'b0;
        chk_bit("mis_trap", MisalignTrap, 1'b1);
        chk_bit("mis_novalid", InstrValid, 1'b0);
        chk_bit("mis_req", ImemReq, 1'b1);
        chk("mis_addr", ImemAddr, TV);
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0;
        chk_bit("mis_trap_once", MisalignTrap, 1'b0);
        ImemRValid = 1'b1;
        ImemRData = mem_word(TV);
        tick();
        ImemRValid = 1'b0;
        chk("trapvec_pc", PC, TV);

        // Redirect coincident with the response in WAIT.
        tick();
        chk("seq_addr", ImemAddr, 32'h104);
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0;
        ImemRValid = 1'b1;
        ImemRData = mem_word(32'h104);
        PCSrc = 1'b1;
        PCTarget = 32'h200;
        tick();
        ImemRValid = 1'b0;
        PCSrc = 1'b0;
        chk_bit("coinc_novalid", InstrValid, 1'b0);
        chk_bit("coinc_req", ImemReq, 1'b1);
        chk("coinc_addr", ImemAddr, 32'h200);
        serve(32'h200);
        chk("coinc_pc", PC, 32'h200);

        // Reset pulsed during WAIT with a late response.
        tick();
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_bit("async_req", ImemReq, 1'b0);
        chk_bit("async_valid", InstrValid, 1'b0);
        chk("async_addr", ImemAddr, RV);
        chk("async_pc", PC, RV);
        chk("async_instr", Instr, NOP);
        ImemRValid = 1'b1;
        ImemRData = mem_word(32'h204);
        tick();
        rst = 1'b1;                          // BOOT cycle, response still high
        tick();
        ImemRValid = 1'b0;
        chk_bit("restart_req", ImemReq, 1'b1);
        chk("restart_addr", ImemAddr, RV);
        chk_bit("restart_novalid", InstrValid, 1'b0);
        serve(RV);
        chk("restart_instr", Instr, 32'h0050_0093);

        // Randomized traffic from a fresh reset.
        Stall = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        outst = 1'b0; prev_gnt = 1'b0; prev_rv = 1'b0; raddr = '0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_gnt) outst = 1'b1;
            if (prev_rv) outst = 1'b0;
            ImemGnt = ImemReq && ($urandom_range(3) != 0);
            if (ImemGnt) raddr = ImemAddr;
            ImemRValid = outst && ($urandom_range(2) != 0);
            ImemRData = ImemRValid ? mem_word(raddr) : $urandom();
            Stall = ($urandom_range(9) < 3);
            PCSrc = ($urandom_range(99) < 6);
            r = $urandom_range(9);
            if (r == 0) PCTarget = 32'hFFFF_FFFC;
            else if (r < 3) PCTarget = ($urandom_range(1023) << 2) | $urandom_range(3, 1);
            else PCTarget = $urandom_range(1023) << 2;
            prev_gnt = ImemGnt;
            prev_rv = ImemRValid;
            tick();
        end
        ImemGnt = 1'b0; ImemRValid = 1'b0; PCSrc = 1'b0; Stall = 1'b0;
        repeat (3) tick();
        chk_bit("presented_min", presented >= 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
